// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the rate-1/2 Viterbi decoder (BMU, ACS, traceback).
// Helpers take the constraint length as an argument so every block can use its own K.
package viterbi_pkg;

    localparam int         K_DEF  = 3;
    localparam logic [2:0] G0_DEF = 3'b111;
    localparam logic [2:0] G1_DEF = 3'b101;
    localparam int         NS_DEF = 1 << (K_DEF - 1);
    localparam int         K_MAX  = 7;

    // Encoder window is {b, state}; the new input bit sits at position k-1.
    function automatic logic [1:0] expected_bits(input int k, input logic [7:0] g0,
                                                 input logic [7:0] g1, input logic [6:0] state,
                                                 input logic b);
        logic [7:0] w;
        w = {1'b0, state} | ({7'd0, b} << (k - 1));
        return {^(w & g0), ^(w & g1)};
    endfunction

    function automatic logic [6:0] next_state(input int k, input logic [6:0] state, input logic b);
        return (state >> 1) | ({6'd0, b} << (k - 2));
    endfunction

    // During warm-up only states whose not-yet-filled low bits are zero can be reached.
    function automatic logic state_legal(input int k, input logic [15:0] idx, input logic [6:0] s);
        int         sh;
        logic [6:0] m;
        if (idx >= 16'(k - 1)) return 1'b1;
        sh = k - 1 - int'(idx);
        m  = 7'((1 << sh) - 1);
        return (s & m) == 7'd0;
    endfunction

endpackage

// File: rtl/viterbi_sym_dist.sv
// Four codeword metrics M[c0c1] for one received symbol pair, with per-bit erasure.
module viterbi_sym_dist
    import viterbi_pkg::*;
#(
    parameter int SOFT_W = 1,
    parameter int BM_W   = SOFT_W + 1
) (
    input  logic [SOFT_W-1:0] r0,
    input  logic [SOFT_W-1:0] r1,
    input  logic [1:0]        erase,
    output logic [BM_W-1:0]   m00,
    output logic [BM_W-1:0]   m01,
    output logic [BM_W-1:0]   m10,
    output logic [BM_W-1:0]   m11
);

    localparam logic [SOFT_W-1:0] MAXV = '1;

    logic [SOFT_W-1:0] d0_e0, d0_e1, d1_e0, d1_e1;

    // An erased bit carries no information, so both hypotheses cost nothing.
    assign d0_e0 = erase[1] ? '0 : r0;
    assign d0_e1 = erase[1] ? '0 : MAXV - r0;
    assign d1_e0 = erase[0] ? '0 : r1;
    assign d1_e1 = erase[0] ? '0 : MAXV - r1;

    assign m00 = BM_W'(d0_e0) + BM_W'(d1_e0);
    assign m01 = BM_W'(d0_e0) + BM_W'(d1_e1);
    assign m10 = BM_W'(d0_e1) + BM_W'(d1_e0);
    assign m11 = BM_W'(d0_e1) + BM_W'(d1_e1);

endmodule

// File: rtl/viterbi_bmu_param.sv
// Branch-metric unit: maps symbol metrics onto every (state, input) branch, adds
// warm-up/tail reachability masks and frame markers behind one handshake register.
module viterbi_bmu_param
    import viterbi_pkg::*;
#(
    parameter int             K         = K_DEF,
    parameter logic [K-1:0]   G0        = G0_DEF,
    parameter logic [K-1:0]   G1        = G1_DEF,
    parameter int             SOFT_W    = 1,
    parameter int             FRAME_LEN = 0,
    parameter int             BM_W      = SOFT_W + 1,
    localparam int            NS        = 1 << (K - 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   refresh,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SOFT_W-1:0]      in_r0,
    input  logic [SOFT_W-1:0]      in_r1,
    input  logic [1:0]             in_erase,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*NS*BM_W-1:0]   out_bm,
    output logic [2*NS-1:0]        out_mask,
    output logic                   out_first,
    output logic                   out_last
);

    localparam logic [15:0] LAST_IDX   = 16'(FRAME_LEN - 1);
    localparam logic [15:0] TAIL_START = 16'(FRAME_LEN - (K - 1));
    localparam logic [15:0] WARM_END   = 16'(K - 1);

    logic [15:0]          idx;
    logic [BM_W-1:0]      metric [4];
    logic [2*NS*BM_W-1:0] bm_next;
    logic [2*NS-1:0]      mask_next;
    logic                 in_tail;
    logic                 accept;

    viterbi_sym_dist #(.SOFT_W(SOFT_W), .BM_W(BM_W)) u_dist (
        .r0    (in_r0),
        .r1    (in_r1),
        .erase (in_erase),
        .m00   (metric[0]),
        .m01   (metric[1]),
        .m10   (metric[2]),
        .m11   (metric[3])
    );

    assign in_ready = !refresh && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign in_tail  = (FRAME_LEN > 0) && (idx >= TAIL_START);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        bm_next   = '0;
        mask_next = '0;
        for (int s = 0; s < NS; s++) begin
            for (int b = 0; b < 2; b++) begin
                bm_next[(2*s+b)*BM_W +: BM_W] = metric[expected_bits(K, 8'(G0), 8'(G1), 7'(s), 1'(b))];
                mask_next[2*s+b] = state_legal(K, idx, 7'(s)) && !(in_tail && b == 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_bm    <= '0;
            out_mask  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (refresh) begin
            idx       <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_bm    <= bm_next;
            out_mask  <= mask_next;
            out_first <= (idx == 16'd0);
            out_last  <= (FRAME_LEN > 0) && (idx == LAST_IDX);
            if (FRAME_LEN > 0)
                idx <= (idx == LAST_IDX) ? 16'd0 : idx + 16'd1;
            else if (idx < WARM_END)
                idx <= idx + 16'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_bmu_param.sv
// Directed bench: hard-decision framed instance (K=3, FRAME_LEN=8) and soft unterminated instance.
module tb_viterbi_bmu_param;

    typedef struct {
        logic [2:0]  r0;
        logic [2:0]  r1;
        logic [1:0]  er;
        logic [31:0] bm;
        logic [7:0]  mask;
        logic        first;
        logic        last;
    } vec_t;

    logic clk, rst;
    int   n_checks, n_fail;

    // hard-decision framed instance
    logic        refresh_h, in_valid_h, in_ready_h, out_valid_h, out_ready_h, out_first_h, out_last_h;
    logic [0:0]  in_r0_h, in_r1_h;
    logic [1:0]  in_erase_h;
    logic [15:0] out_bm_h;
    logic [7:0]  out_mask_h;

    // soft unterminated instance
    logic        refresh_s, in_valid_s, in_ready_s, out_valid_s, out_ready_s, out_first_s, out_last_s;
    logic [2:0]  in_r0_s, in_r1_s;
    logic [1:0]  in_erase_s;
    logic [31:0] out_bm_s;
    logic [7:0]  out_mask_s;

    vec_t hv [10];
    vec_t sv [5];

    viterbi_bmu_param #(.K(3), .G0(3'b111), .G1(3'b101), .SOFT_W(1), .FRAME_LEN(8)) dut_h (
        .clk(clk), .rst(rst), .refresh(refresh_h), .in_valid(in_valid_h), .in_ready(in_ready_h),
        .in_r0(in_r0_h), .in_r1(in_r1_h), .in_erase(in_erase_h), .out_valid(out_valid_h),
        .out_ready(out_ready_h), .out_bm(out_bm_h), .out_mask(out_mask_h),
        .out_first(out_first_h), .out_last(out_last_h)
    );

    viterbi_bmu_param #(.K(3), .G0(3'b111), .G1(3'b101), .SOFT_W(3), .FRAME_LEN(0)) dut_s (
        .clk(clk), .rst(rst), .refresh(refresh_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .in_r0(in_r0_s), .in_r1(in_r1_s), .in_erase(in_erase_s), .out_valid(out_valid_s),
        .out_ready(out_ready_s), .out_bm(out_bm_s), .out_mask(out_mask_s),
        .out_first(out_first_s), .out_last(out_last_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_h(input string name, input logic [15:0] bm, input logic [7:0] mask,
                           input logic first, input logic last);
        check({name, " valid"}, 32'(out_valid_h), 32'd1);
        check({name, " bm"},    32'(out_bm_h),    32'(bm));
        check({name, " mask"},  32'(out_mask_h),  32'(mask));
        check({name, " first"}, 32'(out_first_h), 32'(first));
        check({name, " last"},  32'(out_last_h),  32'(last));
    endtask

    task automatic drive_h(input logic r0, input logic r1, input logic [1:0] er);
        in_valid_h = 1'b1;
        in_r0_h    = r0;
        in_r1_h    = r1;
        in_erase_h = er;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // codewords per slice (s,b): 00,11,11,00,10,01,01,10
        hv[0] = '{3'd1, 3'd1, 2'b00, 32'h5582, 8'h03, 1'b1, 1'b0};
        hv[1] = '{3'd0, 3'd0, 2'b00, 32'h5528, 8'h33, 1'b0, 1'b0};
        hv[2] = '{3'd1, 3'd0, 2'b00, 32'h2855, 8'hFF, 1'b0, 1'b0};
        hv[3] = '{3'd0, 3'd1, 2'b00, 32'h8255, 8'hFF, 1'b0, 1'b0};
        hv[4] = '{3'd0, 3'd1, 2'b10, 32'h4141, 8'hFF, 1'b0, 1'b0};
        hv[5] = '{3'd1, 3'd1, 2'b11, 32'h0000, 8'hFF, 1'b0, 1'b0};
        hv[6] = '{3'd0, 3'd0, 2'b00, 32'h5528, 8'h55, 1'b0, 1'b0};
        hv[7] = '{3'd1, 3'd1, 2'b00, 32'h5582, 8'h55, 1'b0, 1'b1};
        hv[8] = '{3'd1, 3'd1, 2'b00, 32'h5582, 8'h03, 1'b1, 1'b0};
        hv[9] = '{3'd0, 3'd0, 2'b00, 32'h5528, 8'h33, 1'b0, 1'b0};

        sv[0] = '{3'd7, 3'd0, 2'b00, 32'h0EE0_7777, 8'h03, 1'b1, 1'b0};
        sv[1] = '{3'd7, 3'd3, 2'b01, 32'h0770_7007, 8'h33, 1'b0, 1'b0};
        sv[2] = '{3'd3, 3'd5, 2'b00, 32'h9559_8668, 8'hFF, 1'b0, 1'b0};
        sv[3] = '{3'd0, 3'd7, 2'b10, 32'h7007_7007, 8'hFF, 1'b0, 1'b0};
        sv[4] = '{3'd0, 3'd0, 2'b00, 32'h7777_0EE0, 8'hFF, 1'b0, 1'b0};

        rst = 1'b1;
        refresh_h = 1'b0; in_valid_h = 1'b0; out_ready_h = 1'b1;
        in_r0_h = '0; in_r1_h = '0; in_erase_h = '0;
        refresh_s = 1'b0; in_valid_s = 1'b0; out_ready_s = 1'b1;
        in_r0_s = '0; in_r1_s = '0; in_erase_s = '0;
        #12 rst = 1'b0;
        #1;

        check("reset valid", 32'(out_valid_h), 32'd0);
        check("reset bm",    32'(out_bm_h),    32'd0);
        check("reset mask",  32'(out_mask_h),  32'd0);
        check("reset first", 32'(out_first_h), 32'd0);
        check("reset last",  32'(out_last_h),  32'd0);
        check("reset ready", 32'(in_ready_h),  32'd1);

        // full-throughput frame with wrap into the next frame
        for (int i = 0; i < 10; i++) begin
            drive_h(hv[i].r0[0], hv[i].r1[0], hv[i].er);
            check($sformatf("h%0d in_ready", i), 32'(in_ready_h), 32'd1);
            @(posedge clk); #1;
            check_h($sformatf("h%0d", i), hv[i].bm[15:0], hv[i].mask, hv[i].first, hv[i].last);
        end

        // backpressure: word at idx 2 held for 3 cycles while a new symbol waits
        drive_h(1'b1, 1'b0, 2'b00);
        @(posedge clk); #1;
        check_h("bp load", 16'h2855, 8'hFF, 1'b0, 1'b0);
        out_ready_h = 1'b0;
        drive_h(1'b0, 1'b1, 2'b00);
        #1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d in_ready", c), 32'(in_ready_h), 32'd0);
            @(posedge clk); #1;
            check_h($sformatf("bp%0d hold", c), 16'h2855, 8'hFF, 1'b0, 1'b0);
        end
        out_ready_h = 1'b1;
        @(posedge clk); #1;
        check_h("bp release", 16'h8255, 8'hFF, 1'b0, 1'b0);

        // refresh at idx 4 with a concurrent symbol
        refresh_h = 1'b1;
        drive_h(1'b1, 1'b1, 2'b00);
        #1;
        check("refresh in_ready", 32'(in_ready_h), 32'd0);
        @(posedge clk); #1;
        check("refresh valid", 32'(out_valid_h), 32'd0);
        refresh_h = 1'b0;
        @(posedge clk); #1;
        check_h("after refresh", 16'h5582, 8'h03, 1'b1, 1'b0);

        // asynchronous reset pulse in the middle of a cycle
        #2 rst = 1'b1;
        #1;
        check("rst valid", 32'(out_valid_h), 32'd0);
        check("rst bm",    32'(out_bm_h),    32'd0);
        check("rst mask",  32'(out_mask_h),  32'd0);
        check("rst first", 32'(out_first_h), 32'd0);
        #1 rst = 1'b0;
        drive_h(1'b0, 1'b0, 2'b00);
        @(posedge clk); #1;
        check_h("after rst", 16'h5528, 8'h03, 1'b1, 1'b0);
        in_valid_h = 1'b0;
        @(posedge clk); #1;
        check("drain valid", 32'(out_valid_h), 32'd0);

        // soft metrics, erasures and counter saturation without a frame length
        for (int i = 0; i < 5; i++) begin
            in_valid_s = 1'b1;
            in_r0_s    = sv[i].r0;
            in_r1_s    = sv[i].r1;
            in_erase_s = sv[i].er;
            @(posedge clk); #1;
            check($sformatf("s%0d valid", i), 32'(out_valid_s), 32'd1);
            check($sformatf("s%0d bm", i),    out_bm_s,         sv[i].bm);
            check($sformatf("s%0d mask", i),  32'(out_mask_s),  32'(sv[i].mask));
            check($sformatf("s%0d first", i), 32'(out_first_s), 32'(sv[i].first));
            check($sformatf("s%0d last", i),  32'(out_last_s),  32'(sv[i].last));
        end
        in_valid_s = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
